// File: rtl/ans_job_ctrl.sv
// Job sequencer in front of the ans core: optional table load, then N data symbols.
// Drives the core command with idle gaps around every change and tracks the output drain.
module ans_job_ctrl #(
    parameter int LEN_W        = 8,
    parameter int TABLE_LEN    = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_vld,
    output logic             job_rdy,
    input  logic [1:0]       job_mode,
    input  logic             job_load,
    input  logic [LEN_W-1:0] job_len,
    input  logic [3:0]       s_data,
    input  logic             s_vld,
    output logic             s_rdy,
    output logic [1:0]       core_cmd,
    output logic [3:0]       core_in,
    output logic             core_in_vld,
    input  logic             core_in_rdy,
    input  logic             core_out_vld,
    output logic             core_out_rdy,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] sym_left
);
    localparam int TC_W = $clog2(TABLE_LEN + 1);
    localparam int IC_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TC_W-1:0] TBL_LAST  = TC_W'(TABLE_LEN - 1);
    localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP_L, S_LOAD, S_GAP_D, S_DATA, S_DRAIN, S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       core_cmd_reg, core_cmd_next;
    logic [1:0]       mode_reg, mode_next;
    logic [LEN_W-1:0] sym_left_reg, sym_left_next;
    logic [TC_W-1:0]  tbl_cnt_reg, tbl_cnt_next;
    logic [IC_W-1:0]  idle_cnt_reg, idle_cnt_next;
    logic             err_reg, err_next;

    logic accept, mode_legal, in_hs, out_hs, pass_in, pass_out;

    assign accept     = job_vld & job_rdy;
    assign mode_legal = (job_mode == 2'b01) || (job_mode == 2'b10);
    assign in_hs      = s_vld & s_rdy;
    assign out_hs     = core_out_vld & core_out_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_core_in
            assign core_in[gi] = s_data[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            core_cmd_reg <= 2'b00;
            mode_reg     <= 2'b00;
            sym_left_reg <= '0;
            tbl_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            core_cmd_reg <= core_cmd_next;
            mode_reg     <= mode_next;
            sym_left_reg <= sym_left_next;
            tbl_cnt_reg  <= tbl_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && mode_legal) begin
                    if (job_load)           state_next = S_GAP_L;
                    else if (job_len != '0) state_next = S_GAP_D;
                    else                    state_next = S_DONE;
                end
            end
            S_GAP_L: state_next = S_LOAD;
            S_LOAD: begin
                // sym_left still holds the job length until data starts
                if (in_hs && tbl_cnt_reg == TBL_LAST)
                    state_next = (sym_left_reg != '0) ? S_GAP_D : S_DONE;
            end
            S_GAP_D: state_next = S_DATA;
            S_DATA: begin
                if (in_hs && sym_left_reg == LEN_W'(1)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!out_hs && idle_cnt_reg == IDLE_LAST) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mode_next     = mode_reg;
        sym_left_next = sym_left_reg;
        err_next      = err_reg;
        tbl_cnt_next  = (state_reg == S_LOAD && in_hs) ? tbl_cnt_reg + 1'b1 : tbl_cnt_reg;
        idle_cnt_next = '0;
        if (state_reg != S_LOAD) tbl_cnt_next = '0;
        if (state_reg == S_DRAIN && !out_hs) idle_cnt_next = idle_cnt_reg + 1'b1;
        if (accept) begin
            err_next = !mode_legal;
            if (mode_legal) begin
                mode_next     = job_mode;
                sym_left_next = job_len;
            end
        end
        if (state_reg == S_DATA && in_hs) sym_left_next = sym_left_reg - 1'b1;
        // command is registered from the next state so every change lands on a gap edge
        case (state_next)
            S_LOAD:          core_cmd_next = 2'b11;
            S_DATA, S_DRAIN: core_cmd_next = mode_next;
            default:         core_cmd_next = 2'b00;
        endcase
    end

    always_comb begin
        pass_in      = !rst && (state_reg == S_LOAD || state_reg == S_DATA);
        pass_out     = !rst && (state_reg == S_DATA || state_reg == S_DRAIN);
        job_rdy      = !rst && (state_reg == S_IDLE);
        s_rdy        = pass_in & core_in_rdy;
        core_in_vld  = pass_in & s_vld;
        core_out_rdy = pass_out & m_rdy;
        m_vld        = pass_out & core_out_vld;
        busy         = (state_reg != S_IDLE);
        done         = (state_reg == S_DONE);
        err          = err_reg;
        sym_left     = sym_left_reg;
        core_cmd     = core_cmd_reg;
    end
endmodule

// File: tb/tb_ans_job_ctrl.sv
// Self-checking bench for ans_job_ctrl: scenario tasks against expectations built from the job rules.
module tb_ans_job_ctrl;
    localparam int LEN_W = 8;
    localparam int TABLE_LEN = 16;
    localparam int DRAIN = 4;

    logic clk, rst, job_vld, job_rdy, job_load;
    logic [1:0] job_mode, core_cmd;
    logic [LEN_W-1:0] job_len, sym_left;
    logic [3:0] s_data, core_in;
    logic s_vld, s_rdy, core_in_vld, core_in_rdy, core_out_vld, core_out_rdy;
    logic m_vld, m_rdy, busy, done, err;
    int n_tests = 0;
    int n_fail = 0;

    ans_job_ctrl #(.LEN_W(LEN_W), .TABLE_LEN(TABLE_LEN), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .job_vld(job_vld), .job_rdy(job_rdy), .job_mode(job_mode),
        .job_load(job_load), .job_len(job_len), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
        .core_cmd(core_cmd), .core_in(core_in), .core_in_vld(core_in_vld),
        .core_in_rdy(core_in_rdy), .core_out_vld(core_out_vld), .core_out_rdy(core_out_rdy),
        .m_vld(m_vld), .m_rdy(m_rdy), .busy(busy), .done(done), .err(err), .sym_left(sym_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        job_vld = 0; s_vld = 0; core_in_rdy = 0; core_out_vld = 0; m_rdy = 0;
    endtask

    task automatic start_job(input logic [1:0] mode, input logic load, input int len);
        job_mode = mode; job_load = load; job_len = LEN_W'(len); job_vld = 1;
        step();
        job_vld = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        s_vld = 1; core_in_rdy = 1; core_out_vld = 1; m_rdy = 1;
        step(); step();
        @(negedge clk);
        n_tests++;
        if ({job_rdy, s_rdy, core_in_vld, core_out_rdy, m_vld} !== 5'b0) begin
            n_fail++; $display("FAIL reset_gating got=%b want=00000", {job_rdy, s_rdy, core_in_vld, core_out_rdy, m_vld});
        end
        step();
        rst = 0; idle_inputs();
        @(negedge clk);
        n_tests++;
        if ({job_rdy, busy, done, err} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_flags rdy/busy/done/err got=%b want=1000", {job_rdy, busy, done, err});
        end
        n_tests++;
        if (core_cmd !== 2'b00 || sym_left !== '0) begin
            n_fail++; $display("FAIL reset_regs cmd=%b sym_left=%0d want 00/0", core_cmd, sym_left);
        end
        $display("[TB] reset: rdy=%b cmd=%b", job_rdy, core_cmd);
        step();
    endtask

    task automatic test_load_encode();
        logic [1:0] exp_q[$];
        int hs = 0;
        int exp_sym;
        exp_q.push_back(2'b00);
        for (int i = 0; i < TABLE_LEN; i++) exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
        for (int i = 0; i < 3 + DRAIN; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        start_job(2'b01, 1'b1, 3);
        s_vld = 1; core_in_rdy = 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            s_data = 4'($urandom);
            @(negedge clk);
            exp_sym = 3 - ((hs > TABLE_LEN) ? hs - TABLE_LEN : 0);
            n_tests++;
            if (core_cmd !== exp_q[i]) begin
                n_fail++; $display("FAIL load_cmd cycle %0d got=%b want=%b", i, core_cmd, exp_q[i]);
            end
            n_tests++;
            if (int'(sym_left) !== exp_sym) begin
                n_fail++; $display("FAIL load_sym_left cycle %0d got=%0d want=%0d", i, sym_left, exp_sym);
            end
            n_tests++;
            if (done !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL load_done cycle %0d got=%b", i, done);
            end
            if (core_in_vld) begin
                n_tests++;
                if (core_in !== s_data) begin
                    n_fail++; $display("FAIL core_in got=%h want=%h", core_in, s_data);
                end
            end
            if (s_vld && s_rdy) hs++;
            step();
        end
        idle_inputs();
        n_tests++;
        if (hs !== TABLE_LEN + 3) begin
            n_fail++; $display("FAIL load_handshakes got=%0d want=%0d", hs, TABLE_LEN + 3);
        end
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL load_busy_after_done got=%b want=00", {busy, done});
        end
        $display("[TB] load+encode len=3: handshakes=%0d", hs);
        step();
    endtask

    task automatic test_illegal();
        start_job(2'b11, 1'b0, 5);
        @(negedge clk);
        n_tests++;
        if ({err, busy, job_rdy, core_cmd} !== 5'b10100) begin
            n_fail++; $display("FAIL illegal err/busy/rdy/cmd got=%b want=10100", {err, busy, job_rdy, core_cmd});
        end
        step();
        start_job(2'b10, 1'b0, 0);
        @(negedge clk);
        n_tests++;
        if ({done, err, core_cmd} !== 4'b1000) begin
            n_fail++; $display("FAIL len0 done/err/cmd got=%b want=1000", {done, err, core_cmd});
        end
        step();
        @(negedge clk);
        n_tests++;
        if ({done, busy, core_cmd} !== 4'b0000) begin
            n_fail++; $display("FAIL len0_after done/busy/cmd got=%b want=0000", {done, busy, core_cmd});
        end
        $display("[TB] illegal mode then len=0 job: err=%b", err);
        step();
    endtask

    task automatic test_random_data();
        for (int j = 0; j < 4; j++) begin
            logic [1:0] mode, prev_cmd;
            logic prev_vld;
            int len, hs, ndone, cyc;
            mode = ($urandom % 2) ? 2'b01 : 2'b10;
            len = $urandom_range(1, 12);
            start_job(mode, 1'b0, len);
            hs = 0; ndone = 0; cyc = 0; prev_cmd = 2'b00; prev_vld = 0; m_rdy = 1;
            while (ndone == 0 && cyc < 300) begin
                core_in_rdy = cyc[0];
                s_vld = 1'($urandom);
                core_out_vld = 1'($urandom);
                s_data = 4'($urandom);
                @(negedge clk);
                n_tests++;
                if (int'(sym_left) !== len - hs) begin
                    n_fail++; $display("FAIL rnd_sym_left got=%0d want=%0d", sym_left, len - hs);
                end
                n_tests++;
                if (prev_vld && core_cmd !== prev_cmd) begin
                    n_fail++; $display("FAIL rnd_cmd_in_flight got=%b want=%b", core_cmd, prev_cmd);
                end
                n_tests++;
                if (core_cmd !== 2'b00 && core_cmd !== mode) begin
                    n_fail++; $display("FAIL rnd_cmd_value got=%b want=00 or %b", core_cmd, mode);
                end
                n_tests++;
                if (s_rdy && !core_in_rdy) begin
                    n_fail++; $display("FAIL rnd_s_rdy got=1 want=0 (core_in_rdy=0)");
                end
                if (done) ndone++;
                if (s_vld && s_rdy) hs++;
                prev_cmd = core_cmd; prev_vld = core_in_vld;
                cyc++;
                step();
            end
            idle_inputs();
            n_tests++;
            if (hs !== len) begin
                n_fail++; $display("FAIL rnd_handshakes got=%0d want=%0d", hs, len);
            end
            n_tests++;
            if (ndone !== 1) begin
                n_fail++; $display("FAIL rnd_done_count got=%0d want=1", ndone);
            end
            $display("[TB] random data job mode=%b len=%0d handshakes=%0d cycles=%0d", mode, len, hs, cyc);
        end
    endtask

    task automatic test_drain();
        int quiet, done_d, c;
        logic seen;
        m_rdy = 1;
        start_job(2'b01, 1'b0, 1);
        core_out_vld = 1;
        @(negedge clk);
        n_tests++;
        if ({m_vld, core_out_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL gap_out_gating got=%b want=00", {m_vld, core_out_rdy});
        end
        step();
        core_out_vld = 0; s_vld = 1; core_in_rdy = 1;
        @(negedge clk);
        step();
        s_vld = 0; core_in_rdy = 0;
        quiet = 0; seen = 0; done_d = -1;
        for (int d = 0; d < 30 && !seen; d++) begin
            core_out_vld = (d < 6) && (d % 2 == 0);
            @(negedge clk);
            n_tests++;
            if (done !== (quiet >= DRAIN)) begin
                n_fail++; $display("FAIL drain_done d=%0d got=%b quiet=%0d", d, done, quiet);
            end
            if (done) begin
                seen = 1; done_d = d;
            end else begin
                n_tests++;
                if (m_vld !== core_out_vld) begin
                    n_fail++; $display("FAIL drain_m_vld got=%b want=%b", m_vld, core_out_vld);
                end
                if (core_out_vld && core_out_rdy) quiet = 0;
                else quiet++;
            end
            step();
        end
        n_tests++;
        if (done_d !== 4 + DRAIN + 1) begin
            n_fail++; $display("FAIL drain_done_cycle got=%0d want=%0d", done_d, 4 + DRAIN + 1);
        end
        $display("[TB] drain with output pulses: done at drain cycle %0d", done_d);
        idle_inputs();
        start_job(2'b10, 1'b0, 1);
        step();
        s_vld = 1; core_in_rdy = 1;
        step();
        s_vld = 0; core_in_rdy = 0; core_out_vld = 1;
        done_d = -1;
        for (c = 3; c < 30 && done_d < 0; c++) begin
            @(negedge clk);
            n_tests++;
            if (core_out_rdy !== 1'b0) begin
                n_fail++; $display("FAIL drain_mrdy0_out_rdy got=%b want=0", core_out_rdy);
            end
            if (done) done_d = c;
            step();
        end
        idle_inputs();
        n_tests++;
        if (done_d !== 3 + DRAIN) begin
            n_fail++; $display("FAIL min_job_done_cycle got=E+%0d want=E+%0d", done_d, 3 + DRAIN);
        end
        $display("[TB] minimum job with m_rdy=0: done at E+%0d", done_d);
    endtask

    task automatic test_max_len();
        int hs = 0;
        int cyc = 0;
        logic seen = 0;
        localparam int MAXLEN = (1 << LEN_W) - 1;
        start_job(2'b10, 1'b0, MAXLEN);
        s_vld = 1; core_in_rdy = 1;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            n_tests++;
            if (int'(sym_left) !== MAXLEN - hs) begin
                n_fail++; $display("FAIL max_sym_left got=%0d want=%0d", sym_left, MAXLEN - hs);
            end
            if (done) seen = 1;
            if (s_vld && s_rdy) hs++;
            cyc++;
            step();
        end
        idle_inputs();
        n_tests++;
        if (hs !== MAXLEN || seen !== 1'b1) begin
            n_fail++; $display("FAIL max_len handshakes=%0d done_seen=%b want %0d/1", hs, seen, MAXLEN);
        end
        $display("[TB] max length job: handshakes=%0d cycles=%0d", hs, cyc);
    endtask

    task automatic test_reset_mid_load();
        int hs = 0;
        int done_c = -1;
        start_job(2'b01, 1'b1, 2);
        step();
        s_vld = 1; core_in_rdy = 1;
        repeat (5) step();
        rst = 1;
        @(negedge clk);
        n_tests++;
        if (s_rdy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_s_rdy got=%b want=0", s_rdy);
        end
        step();
        rst = 0;
        @(negedge clk);
        n_tests++;
        if ({core_cmd, done, job_rdy, busy} !== 5'b00010) begin
            n_fail++; $display("FAIL rst_mid cmd/done/rdy/busy got=%b want=00010", {core_cmd, done, job_rdy, busy});
        end
        step();
        start_job(2'b01, 1'b1, 0);
        for (int c = 1; c < 60 && done_c < 0; c++) begin
            @(negedge clk);
            if (done) done_c = c;
            if (s_vld && s_rdy) hs++;
            step();
        end
        idle_inputs();
        n_tests++;
        if (done_c !== TABLE_LEN + 2 || hs !== TABLE_LEN) begin
            n_fail++; $display("FAIL reload_after_rst done=E+%0d hs=%0d want E+%0d/%0d", done_c, hs, TABLE_LEN + 2, TABLE_LEN);
        end
        $display("[TB] reset mid-load then load-only job: done at E+%0d", done_c);
    endtask

    initial begin
        rst = 1; job_mode = 0; job_load = 0; job_len = 0; s_data = 0;
        idle_inputs();
        test_reset();
        test_load_encode();
        test_illegal();
        test_random_data();
        test_drain();
        test_max_len();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ans_job_ctrl.md
# ans_job_ctrl

Job-level sequencer sitting between the host pins and the `ans` core. Accepts one job at a time: an optional 16-entry frequency-table load, then N symbols of encode or decode. It drives the core's `cmd` lines itself and inserts idle gaps so `cmd` never changes while data is in flight. It tracks the output drain and reports completion, errors and remaining symbol count to the host.

## Interface
Parameters:
- `LEN_W`, default 8: width of the job length and remaining-symbol counter.
- `TABLE_LEN`, default 16: number of count nibbles per table load.
- `DRAIN_CYCLES`, default 4, minimum 1: consecutive cycles with no output handshake that end a job.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `job_vld`  in  1  host job request.
- `job_rdy`  out  1  controller can accept a job; high only in IDLE.
- `job_mode`  in  2  01 = encode, 10 = decode; 00 and 11 are illegal.
- `job_load`  in  1  load a frequency table before the data phase.
- `job_len`  in  LEN_W  number of data symbols in the job.
- `s_data`  in  4  host symbol/nibble stream.
- `s_vld`  in  1  host stream valid.
- `s_rdy`  out  1  host stream ready.
- `core_cmd`  out  2  registered mode to the core: 00 idle, 01 enc, 10 dec, 11 load.
- `core_in`  out  4  equals `s_data`.
- `core_in_vld`  out  1  gated `s_vld`.
- `core_in_rdy`  in  1  core input ready.
- `core_out_vld`  in  1  core output valid.
- `core_out_rdy`  out  1  gated `m_rdy`.
- `m_vld`  out  1  gated `core_out_vld` to the host (data path bypasses this block).
- `m_rdy`  in  1  host output ready.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky illegal-mode flag; cleared on the next legal job accept.
- `sym_left`  out  LEN_W  data symbols remaining in the current job.

## Operation
- States: IDLE, GAP_L, LOAD, GAP_D, DATA, DRAIN, DONE.
- Input handshake fires when `s_vld & s_rdy`; output handshake fires when `core_out_vld & core_out_rdy`.
- IDLE:
  - `core_cmd` = 00.
  - On `job_vld & job_rdy`, capture mode, load flag and length; `sym_left` <= `job_len`.
  - Illegal mode: set `err`, drop the job, stay in IDLE.
  - Otherwise clear `err`, then: load=1 -> GAP_L; load=0 and len≠0 -> GAP_D; load=0 and len=0 -> DONE.
- GAP_L: one cycle with `core_cmd` = 00, then -> LOAD; `core_cmd` <= 11.
- LOAD:
  - `s_rdy` = `core_in_rdy`; `core_in_vld` = `s_vld`.
  - Count input handshakes 0..TABLE_LEN-1.
  - On the TABLE_LEN-th handshake: -> GAP_D if len≠0, else -> DONE.
- GAP_D: one cycle with `core_cmd` = 00, then -> DATA; `core_cmd` <= captured mode.
- DATA:
  - Same input pass-through as LOAD.
  - Each input handshake decrements `sym_left`.
  - The handshake that takes `sym_left` from 1 to 0 -> DRAIN.
- DRAIN:
  - `core_cmd` holds the mode; `s_rdy` = 0, `core_in_vld` = 0.
  - An idle counter clears on each output handshake and increments otherwise.
  - After DRAIN_CYCLES consecutive non-handshake cycles -> DONE.
- DONE: `core_cmd` = 00, `done` = 1 for this cycle only, then -> IDLE.
- Output gating: `core_out_rdy` = `m_rdy` and `m_vld` = `core_out_vld` only in DATA and DRAIN; both are 0 elsewhere.
- Outside LOAD and DATA: `s_rdy` = 0 and `core_in_vld` = 0.
- `job_vld` while `busy` is ignored (`job_rdy` = 0).

## Timing
- Reset (synchronous): state IDLE, `core_cmd` = 00, `sym_left` = 0, `err` = 0, `done` = 0, counters 0.
  - While `rst` is high, `job_rdy`, `s_rdy`, `core_in_vld`, `core_out_rdy` and `m_vld` are 0.
  - `job_rdy` = 1 from the first cycle after `rst` falls.
- Reset mid-job aborts the job: `core_cmd` = 00 after the reset edge, no `done` pulse, partial table load discarded.
- Accept at edge E: GAP at cycle E+1; `core_cmd` shows 11 (or mode) from edge E+2.
- `core_cmd` never changes in a cycle where `core_in_vld` is 1; every change passes through 00 for at least one cycle.
- Stream gating is combinational and zero-latency; `s_rdy` follows `core_in_rdy` in the same cycle.
- Minimum job (load=0, len=1, no output): accept, GAP_D, DATA (1 cycle), DRAIN (DRAIN_CYCLES cycles), DONE. `done` is high at cycle E+3+DRAIN_CYCLES.
- `sym_left` is registered and updates on the edge of each DATA handshake.
- `job_len` = 2^LEN_W−1 must complete with no counter wrap.

## Test plan
- Reset, then job mode=01, load=1, len=3; 16 table nibbles and 3 symbols with `core_in_rdy`=1 -> `core_cmd` sequence 00,11×16,00,01…; `sym_left` 3→0; `done` pulse once; `busy` falls with `done`.
- Job mode=11 -> `err`=1, no state change, `busy`=0. A following legal job clears `err` on accept.
- Job mode=10, load=0, len=0 -> `done` at E+1 and `core_cmd` stays 00 throughout.
- DATA phase with `core_in_rdy` toggling every cycle and `s_vld` random -> exactly `len` handshakes; `core_cmd` stable during the phase.
- DRAIN with `core_out_vld` pulses at 2-cycle spacing, DRAIN_CYCLES=4 -> no DONE until 4 quiet cycles after the last output handshake. With `m_rdy`=0, output handshakes never fire and DONE comes 4 cycles after DRAIN entry.
- Assert `rst` for one cycle in the middle of LOAD -> next cycle IDLE, `core_cmd`=00, `done`=0, `job_rdy`=1.
